// File: rtl/pbs_pkg.sv
// -----------------------------------------------------------------------------
// pbs_pkg
// Shared constants for the battle player-input path:
//   - move codes presented on the switches and carried to the battle FSM
//   - one-bit state encoding of the move hand-off FSM
//   - saturating increment used by the optional accepted-move counter
// -----------------------------------------------------------------------------
package pbs_pkg;

    // Move codes selected on sw_move.
    localparam logic [1:0] MOVE_ATTACK = 2'd0;
    localparam logic [1:0] MOVE_HEAL   = 2'd1;
    localparam logic [1:0] MOVE_CATCH  = 2'd2;
    localparam logic [1:0] MOVE_RSVD   = 2'd3;

    // Move hand-off FSM states.
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    // Accepted-move counter ceiling (fits one hex digit).
    localparam logic [3:0] ACCEPT_MAX = 4'd15;

    // Increment a 4-bit count, holding at ACCEPT_MAX instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] value);
        logic [3:0] result;
        if (value == ACCEPT_MAX) begin
            result = value;
        end else begin
            result = value + 4'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Two-flop synchroniser, level debouncer and press detector for one active-low
// push button that is asynchronous to clk.
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset (sync stages and level reset
//                   to 1 = released, counter to 0)
//   key_n_i    in   raw button, active-low
//   press_o    out  one-cycle pulse when the debounced level goes 1 -> 0
// A level change is accepted only after DBNC_CYCLES consecutive synchronised
// samples that differ from the current debounced level.
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int unsigned DBNC_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n_i,
    output logic press_o
);

    localparam int unsigned CNT_W = ($clog2(DBNC_CYCLES) < 1) ? 1 : $clog2(DBNC_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DBNC_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;

    // Debounce next-state: count disagreeing samples, accept on the last one.
    always_comb begin
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (sync2_q == deb_q) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
            deb_d   = sync2_q;
            cnt_d   = CNT_ZERO;
            // Only the press direction produces an event; releases are silent.
            press_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Synchroniser, debounced level, counter and registered press pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b1;
            cnt_q   <= CNT_ZERO;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/move_input_reader.sv
// -----------------------------------------------------------------------------
// move_input_reader
// Carries the player's turn choice into the battle control FSM: debounces the
// confirm/cancel buttons, latches sw_move on a confirm press and offers it as
// one move per valid/ready handshake. Only one move is ever outstanding.
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   key_confirm_n  in   raw confirm button, active-low, asynchronous
//   key_cancel_n   in   raw cancel button, active-low, asynchronous
//   sw_move        in   move select switches [MOVE_W]
//   move_valid     out  a move is pending on move_code
//   move_code      out  latched move [MOVE_W], stable while move_valid
//   move_ready     in   consumer accepts the move (transfer on valid & ready)
//   pending_led    out  mirrors move_valid
// Optional feature, macro MOVE_READER_LAST_EN:
//   last_move      out  code of the most recently transferred move [MOVE_W]
//   accept_cnt     out  number of transfers, saturating at 15 [4]
// Key fall to move_valid high is DBNC_CYCLES+3 clock edges (2 sync stages,
// DBNC_CYCLES debounce samples, 1 FSM edge).
// -----------------------------------------------------------------------------
module move_input_reader
    import pbs_pkg::*;
#(
    parameter int unsigned DBNC_CYCLES = 16,
    parameter int unsigned MOVE_W      = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              key_confirm_n,
    input  logic              key_cancel_n,
    input  logic [MOVE_W-1:0] sw_move,
    output logic              move_valid,
    output logic [MOVE_W-1:0] move_code,
    input  logic              move_ready,
    output logic              pending_led
`ifdef MOVE_READER_LAST_EN
    ,
    output logic [MOVE_W-1:0] last_move,
    output logic [3:0]        accept_cnt
`endif
);

    logic              confirm_press_s;
    logic              cancel_press_s;
    logic              handshake_s;

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic              valid_q;
    logic              valid_d;
    logic [MOVE_W-1:0] code_q;
    logic [MOVE_W-1:0] code_d;
    logic              led_q;

    key_debounce #(
        .DBNC_CYCLES (DBNC_CYCLES)
    ) u_confirm_dbnc (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n_i (key_confirm_n),
        .press_o (confirm_press_s)
    );

    key_debounce #(
        .DBNC_CYCLES (DBNC_CYCLES)
    ) u_cancel_dbnc (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n_i (key_cancel_n),
        .press_o (cancel_press_s)
    );

    assign handshake_s = valid_q & move_ready;

    // Move FSM next-state: latch on confirm, release on handshake or cancel.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                // A simultaneous cancel press vetoes the confirm.
                if (confirm_press_s && !cancel_press_s) begin
                    state_d = PENDING;
                    valid_d = 1'b1;
                    code_d  = sw_move;
                end else begin
                    state_d = IDLE;
                end
            end
            PENDING: begin
                // Handshake is checked first so a same-cycle cancel cannot
                // discard a move the consumer has already taken.
                if (handshake_s) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else if (cancel_press_s) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else begin
                    state_d = PENDING;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Move FSM state, latched code and LED; reset drops valid immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            code_q  <= {MOVE_W{1'b0}};
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            led_q   <= valid_d;
        end
    end

    assign move_valid  = valid_q;
    assign move_code   = code_q;
    assign pending_led = led_q;

`ifdef MOVE_READER_LAST_EN
    logic [MOVE_W-1:0] last_q;
    logic [MOVE_W-1:0] last_d;
    logic [3:0]        acc_q;
    logic [3:0]        acc_d;

    // Transfer history next-state: capture code and count on each handshake.
    always_comb begin
        last_d = last_q;
        acc_d  = acc_q;
        if (handshake_s) begin
            last_d = code_q;
            acc_d  = sat_inc4(acc_q);
        end else begin
            last_d = last_q;
            acc_d  = acc_q;
        end
    end

    // Transfer history registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= {MOVE_W{1'b0}};
            acc_q  <= 4'd0;
        end else begin
            last_q <= last_d;
            acc_q  <= acc_d;
        end
    end

    assign last_move  = last_q;
    assign accept_cnt = acc_q;
`endif

endmodule

// File: tb/tb_move_input_reader.sv
// -----------------------------------------------------------------------------
// tb_move_input_reader
// Directed scenarios followed by a randomized phase. A reference model keeps a
// history of raw key samples per button and applies the rules directly: a
// debounced level flips when the DBNC_CYCLES samples seen after the two sync
// stages all disagree with it, a flip to 0 is a press, and the press acts on
// the move state one edge later. Offers and handshakes predicted by the model
// are queued; a monitor pops them when the DUT raises valid or transfers.
// -----------------------------------------------------------------------------
module tb_move_input_reader;
    import pbs_pkg::*;

    localparam int D  = 4;
    localparam int MW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          kc_n = 1'b1;
    logic          kx_n = 1'b1;
    logic          ready = 1'b0;
    logic [MW-1:0] sw = 2'd0;
    logic          move_valid;
    logic [MW-1:0] move_code;
    logic          pending_led;
`ifdef MOVE_READER_LAST_EN
    logic [MW-1:0] last_move;
    logic [3:0]    accept_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [MW-1:0] exp_offer[$];
    logic [MW-1:0] exp_hs[$];

    // Reference model state.
    logic          mh[2][D+1];
    logic          mdeb[2];
    logic          mpress[2];
    logic          m_valid = 1'b0;
    logic [MW-1:0] m_code = 2'd0;
    logic [MW-1:0] m_last = 2'd0;
    int            m_acc = 0;

    move_input_reader #(
        .DBNC_CYCLES (D),
        .MOVE_W      (MW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .key_confirm_n (kc_n),
        .key_cancel_n  (kx_n),
        .sw_move       (sw),
        .move_valid    (move_valid),
        .move_code     (move_code),
        .move_ready    (ready),
        .pending_led   (pending_led)
`ifdef MOVE_READER_LAST_EN
        ,
        .last_move     (last_move),
        .accept_cnt    (accept_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One model step per rising clock edge.
    task automatic model_step();
        logic raw[2];
        logic all_diff;
        raw[0] = kc_n;
        raw[1] = kx_n;
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j <= D; j++) mh[k][j] = 1'b1;
                mdeb[k]   = 1'b1;
                mpress[k] = 1'b0;
            end
            m_valid = 1'b0;
            m_code  = 2'd0;
            m_last  = 2'd0;
            m_acc   = 0;
        end else begin
            // Presses detected at the previous edge act now.
            if (m_valid) begin
                if (ready) begin
                    exp_hs.push_back(m_code);
                    m_last  = m_code;
                    m_acc   = (m_acc < 15) ? m_acc + 1 : 15;
                    m_valid = 1'b0;
                end else if (mpress[1]) begin
                    m_valid = 1'b0;
                end
            end else if (mpress[0] && !mpress[1]) begin
                m_valid = 1'b1;
                m_code  = sw;
                exp_offer.push_back(sw);
            end
            // mh[k][j] is the raw sample from j+1 edges ago; the debouncer
            // sees samples two edges old, so the window is mh[k][1..D].
            for (int k = 0; k < 2; k++) begin
                all_diff = 1'b1;
                for (int j = 1; j <= D; j++) begin
                    if (mh[k][j] == mdeb[k]) all_diff = 1'b0;
                end
                mpress[k] = 1'b0;
                if (all_diff) begin
                    mdeb[k]   = ~mdeb[k];
                    mpress[k] = (mdeb[k] == 1'b0);
                end
                for (int j = D; j >= 1; j--) mh[k][j] = mh[k][j-1];
                mh[k][0] = raw[k];
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: per-cycle state compare plus scoreboard pops on offers/transfers.
    initial begin
        logic          prev_valid;
        logic [MW-1:0] prev_code;
        logic [MW-1:0] e;
        prev_valid = 1'b0;
        prev_code  = 2'd0;
        forever begin
            @(posedge clk);
            #1;
            chk("valid_vs_model", move_valid, m_valid);
            chk("led_vs_valid", pending_led, m_valid);
            chk("code_vs_model", move_code, m_code);
`ifdef MOVE_READER_LAST_EN
            chk("last_vs_model", last_move, m_last);
            chk("acc_vs_model", accept_cnt, m_acc);
`endif
            if (prev_valid && ready && reset_n) begin
                if (exp_hs.size() == 0) begin
                    chk("unexpected_handshake", 32'd1, 32'd0);
                end else begin
                    e = exp_hs.pop_front();
                    chk("handshake_code", prev_code, e);
                end
            end
            if (!prev_valid && move_valid) begin
                if (exp_offer.size() == 0) begin
                    chk("unexpected_offer", 32'd1, 32'd0);
                end else begin
                    e = exp_offer.pop_front();
                    chk("offer_code", move_code, e);
                end
            end
            prev_valid = move_valid;
            prev_code  = move_code;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input logic want, input int budget, input string name);
        int t;
        t = 0;
        while (move_valid !== want && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk(name, move_valid, want);
    endtask

    task automatic press_conf(input int len);
        kc_n = 1'b0;
        tick(len);
        kc_n = 1'b1;
    endtask

    task automatic press_canc(input int len);
        kx_n = 1'b0;
        tick(len);
        kx_n = 1'b1;
    endtask

    task automatic pulse_ready();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
    endtask

    initial begin
        // Reset with bouncing keys.
        reset_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            kc_n = 1'($urandom_range(0, 1));
            kx_n = 1'($urandom_range(0, 1));
        end
        chk("reset_valid", move_valid, 1'b0);
        chk("reset_code", move_code, 2'd0);
        @(negedge clk);
        kc_n = 1'b1;
        kx_n = 1'b1;
        reset_n = 1'b1;
        tick(20);
        chk("idle_valid", move_valid, 1'b0);

        // Clean press: latency DBNC_CYCLES+3 edges after the fall.
        sw = MOVE_CATCH;
        kc_n = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk);
            #1;
            if (e == 6) chk("latency_edge6", move_valid, 1'b0);
            if (e == 7) chk("latency_edge7", move_valid, 1'b1);
        end
        @(negedge clk);
        tick(2);
        kc_n = 1'b1;
        sw = MOVE_HEAL;
        tick(30);
        chk("hold_valid", move_valid, 1'b1);
        chk("hold_code", move_code, MOVE_CATCH);
        pulse_ready();
        chk("ready_drop", move_valid, 1'b0);

        // Bounce and short pulses must not produce a move.
        tick(10);
        for (int i = 0; i < 10; i++) begin
            kc_n = ~kc_n;
            tick(2);
        end
        kc_n = 1'b1;
        tick(20);
        chk("bounce_no_move", move_valid, 1'b0);
        repeat (3) begin
            kc_n = 1'b0;
            tick(3);
            kc_n = 1'b1;
            tick(6);
        end
        chk("pulse3_no_move", move_valid, 1'b0);
        // A pulse of exactly DBNC_CYCLES samples is accepted.
        sw = MOVE_RSVD;
        kc_n = 1'b0;
        tick(4);
        kc_n = 1'b1;
        wait_valid(1'b1, 20, "pulse4_accept");
        chk("pulse4_code", move_code, MOVE_RSVD);
        pulse_ready();
        tick(10);

        // Cancel keeps the last code.
        sw = MOVE_HEAL;
        press_conf(8);
        wait_valid(1'b1, 20, "cancel_setup");
        sw = MOVE_RSVD;
        press_canc(8);
        wait_valid(1'b0, 20, "cancel_drop");
        chk("cancel_code_kept", move_code, MOVE_HEAL);
        tick(10);
        // Confirm and cancel together in IDLE: cancel wins.
        kc_n = 1'b0;
        kx_n = 1'b0;
        tick(8);
        kc_n = 1'b1;
        kx_n = 1'b1;
        tick(20);
        chk("both_press_idle", move_valid, 1'b0);

        // Reset mid-operation drops valid before the next edge. The confirm
        // key stays low through reset; the debouncer restarts released, so
        // the model decides whether a new press follows.
        sw = MOVE_ATTACK;
        kc_n = 1'b0;
        wait_valid(1'b1, 20, "midreset_setup");
        tick(2);
        reset_n = 1'b0;
        #1;
        chk("async_drop_valid", move_valid, 1'b0);
        chk("async_drop_led", pending_led, 1'b0);
        tick(3);
        reset_n = 1'b1;
        tick(15);
        kc_n = 1'b1;
        pulse_ready();
        tick(10);

        // Fresh reset so the transfer count starts from zero.
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(5);
`ifdef MOVE_READER_LAST_EN
        chk("acc_after_reset", accept_cnt, 4'd0);
`endif

        // Handshake and cancel press on the same edge: handshake wins.
        sw = MOVE_CATCH;
        press_conf(8);
        wait_valid(1'b1, 20, "hs_cancel_setup");
        tick(3);
        sw = MOVE_HEAL;
        kx_n = 1'b0;
        tick(6);
        chk("hs_cancel_pre", move_valid, 1'b1);
        pulse_ready();
        chk("hs_cancel_drop", move_valid, 1'b0);
`ifdef MOVE_READER_LAST_EN
        chk("hs_cancel_last", last_move, MOVE_CATCH);
        chk("hs_cancel_acc", accept_cnt, 4'd1);
`endif
        tick(4);
        kx_n = 1'b1;
        tick(10);

        // Seventeen more transfers: the count saturates at 15.
        for (int i = 0; i < 17; i++) begin
            sw = MW'($urandom_range(0, 3));
            press_conf(6);
            wait_valid(1'b1, 20, "multi_setup");
            pulse_ready();
            tick(8);
        end
`ifdef MOVE_READER_LAST_EN
        chk("acc_saturate", accept_cnt, 4'd15);
`endif

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) kc_n = ~kc_n;
            if ($urandom_range(0, 19) == 0) kx_n = ~kx_n;
            ready = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) sw = MW'($urandom_range(0, 3));
        end
        kc_n = 1'b1;
        kx_n = 1'b1;
        ready = 1'b1;
        tick(20);
        ready = 1'b0;
        tick(5);
        chk("drain_valid", move_valid, 1'b0);
        chk("offers_pending", exp_offer.size(), 32'd0);
        chk("handshakes_pending", exp_hs.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
